gpio_in_6502: RTL and testbench

- Bus-responder peripheral that owns the input direction of the SoC GPIO: it samples the external gpio_i pins and presents them to the 6502 core as memory-mapped registers.
- Pin path: two-flop synchroniser, optional per-bit glitch filter, per-bit edge capture with configurable polarity, maskable level interrupt.
- Sits on the SoC data bus beside the gpio_o output register and is decoded by the SoC address decoder.

---
 rtl/gpio_in_6502_pkg.sv | 18 +
 rtl/gpio_in_filter.sv | 61 ++++++
 rtl/gpio_in_6502.sv | 95 +++++++++
 tb/tb_gpio_in_6502.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_6502_pkg.sv
// Shared definitions for the GPIO input block: register addresses used by the
// SoC decoder and firmware headers, plus sizing helpers.
package gpio_in_6502_pkg;

    localparam logic [1:0] GPIO_IN_PIN  = 2'd0;
    localparam logic [1:0] GPIO_IN_EDGE = 2'd1;
    localparam logic [1:0] GPIO_IN_MASK = 2'd2;
    localparam logic [1:0] GPIO_IN_POL  = 2'd3;

    localparam int GPIO_IN_BUS_W = 8;
    localparam int FILT_CNT_W    = 4;

    // Prescaler counter width; a 1-cycle prescaler still needs one bit.
    function automatic int prescale_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// Single GPIO input bit: two-flop synchroniser followed by a tick-paced glitch
// filter (or a plain register when FILTER_LEN is 0).
module gpio_in_filter
    import gpio_in_6502_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pin,
    output logic filt
);

    logic sync_q1;
    logic sync_q2;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
        end
    end

    if (FILTER_LEN == 0) begin : g_bypass
        logic unused_tick;
        assign unused_tick = tick;

        always_ff @(posedge clk) begin
            if (reset) filt <= 1'b0;
            else       filt <= sync_q2;
        end
    end else begin : g_filter
        localparam logic [FILT_CNT_W-1:0] LEN = FILT_CNT_W'(FILTER_LEN);
        logic [FILT_CNT_W-1:0] cnt;

        // Any return of sync to filt restarts the count, so only an input that
        // stays different for FILTER_LEN consecutive ticks is accepted.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt  <= '0;
                filt <= 1'b0;
            end else if (sync_q2 == filt) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == LEN - 1'b1) begin
                    filt <= sync_q2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpio_in_6502.sv
// GPIO input responder for the 6502 SoC bus: filtered pin readback, sticky
// polarity-selectable edge flags and a maskable level interrupt.
module gpio_in_6502
    import gpio_in_6502_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 16,
    parameter int FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    input  logic [WIDTH-1:0] gpio_i,
    output logic             irq
);

    localparam int PS_W = prescale_width(PRESCALE);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  ps_cnt;
    logic             tick;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] edge_flags;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] pol_q;
    logic [WIDTH-1:0] w1c;
    logic             wr;
    logic             rd;

    assign tick = (ps_cnt == PS_MAX);

    always_ff @(posedge clk) begin
        if (reset)     ps_cnt <= '0;
        else if (tick) ps_cnt <= '0;
        else           ps_cnt <= ps_cnt + 1'b1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_in_filter #(
            .FILTER_LEN(FILTER_LEN)
        ) u_filter (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .pin  (gpio_i[i]),
            .filt (filt[i])
        );
    end

    assign wr = cs & we;
    assign rd = cs & ~we;
    assign ev = (pol_q & filt_d & ~filt) | (~pol_q & ~filt_d & filt);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w1c = '0;
        if (wr && addr == GPIO_IN_EDGE) w1c = din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_d     <= '0;
            edge_flags <= '0;
            mask_q     <= '0;
            pol_q      <= '0;
            irq        <= 1'b0;
            dout       <= '0;
        end else begin
            filt_d <= filt;
            // A new event in the same cycle as its W1C keeps the flag set.
            edge_flags <= (edge_flags & ~w1c) | ev;
            irq        <= |(edge_flags & mask_q);

            if (wr && addr == GPIO_IN_MASK) mask_q <= din;
            if (wr && addr == GPIO_IN_POL)  pol_q  <= din;

            if (rd) begin
                case (addr)
                    GPIO_IN_PIN:  dout <= filt;
                    GPIO_IN_EDGE: dout <= edge_flags;
                    GPIO_IN_MASK: dout <= mask_q;
                    default:      dout <= pol_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_in_6502.sv
// Directed and randomized checks of gpio_in_6502: a bypass instance for bus and
// edge/irq behaviour and a filtered instance for glitch rejection.
module tb_gpio_in_6502;

    localparam logic [1:0] A_PIN  = 2'd0;
    localparam logic [1:0] A_EDGE = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_POL  = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_b, cs_f, we;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout_b, dout_f;
    logic [7:0] gpio_b, gpio_f;
    logic       irq_b, irq_f;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state for the randomized bypass phase.
    logic [7:0] m_pin, m_edge, m_mask, m_pol;

    always #5 clk = ~clk;

    gpio_in_6502 #(.WIDTH(8), .PRESCALE(16), .FILTER_LEN(0)) dut_byp (
        .clk(clk), .reset(reset), .cs(cs_b), .we(we), .addr(addr), .din(din),
        .dout(dout_b), .gpio_i(gpio_b), .irq(irq_b)
    );

    gpio_in_6502 #(.WIDTH(8), .PRESCALE(4), .FILTER_LEN(3)) dut_flt (
        .clk(clk), .reset(reset), .cs(cs_f), .we(we), .addr(addr), .din(din),
        .dout(dout_f), .gpio_i(gpio_f), .irq(irq_f)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input bit f, input logic [1:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; din = d;
        if (f) cs_f = 1'b1; else cs_b = 1'b1;
        @(negedge clk);
        cs_b = 1'b0; cs_f = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input bit f, input logic [1:0] a, output logic [7:0] d);
        we = 1'b0; addr = a;
        if (f) cs_f = 1'b1; else cs_b = 1'b1;
        @(negedge clk);
        d = f ? dout_f : dout_b;
        cs_b = 1'b0; cs_f = 1'b0;
    endtask

    task automatic check_reg(input bit f, input logic [1:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        bus_read(f, a, d);
        check(tag, d, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v, rise, fall, one_hot;
        int         op, b, len;
        bit         short_pulse;

        reset = 1'b1; cs_b = 1'b0; cs_f = 1'b0; we = 1'b0;
        addr = '0; din = '0; gpio_b = '0; gpio_f = '0;
        cycles(3);
        check("reset_dout_b", dout_b, 8'h00);
        check("reset_irq_b", {7'b0, irq_b}, 8'h00);
        check("reset_dout_f", dout_f, 8'h00);
        check("reset_irq_f", {7'b0, irq_f}, 8'h00);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            check_reg(1'b0, 2'(a), 8'h00, "reset_reg_b");
            check_reg(1'b1, 2'(a), 8'h00, "reset_reg_f");
        end

        // Bypass latency: filt updates on the third edge after the pin change.
        gpio_b = 8'hA5;
        cycles(2);
        we = 1'b0; addr = A_PIN; cs_b = 1'b1;
        @(negedge clk);
        check("pin_before_lat", dout_b, 8'h00);
        @(negedge clk);
        check("pin_after_lat", dout_b, 8'hA5);
        cs_b = 1'b0;
        cycles(2);
        check_reg(1'b0, A_EDGE, 8'hA5, "edge_rise_a5");
        check("irq_unmasked", {7'b0, irq_b}, 8'h00);
        bus_write(1'b0, A_EDGE, 8'hA5);
        check_reg(1'b0, A_EDGE, 8'h00, "edge_w1c");
        check_reg(1'b0, A_PIN, 8'hA5, "pin_write_ignored_pre");
        bus_write(1'b0, A_PIN, 8'h3C);
        check_reg(1'b0, A_PIN, 8'hA5, "pin_write_ignored");

        // Falling-edge interrupt on bit0.
        bus_write(1'b0, A_POL, 8'h01);
        bus_write(1'b0, A_MASK, 8'h01);
        check("pol_no_edge_irq", {7'b0, irq_b}, 8'h00);
        gpio_b = 8'hA4;
        cycles(4);
        check("irq_lag", {7'b0, irq_b}, 8'h00);
        cycles(1);
        check("irq_fall", {7'b0, irq_b}, 8'h01);
        check_reg(1'b0, A_EDGE, 8'h01, "edge_fall");
        check_reg(1'b0, A_EDGE, 8'h01, "edge_read_no_clear");
        bus_write(1'b0, A_EDGE, 8'h01);
        cycles(1);
        check("irq_after_w1c", {7'b0, irq_b}, 8'h00);
        gpio_b = 8'hA5;
        cycles(6);
        check_reg(1'b0, A_EDGE, 8'h00, "no_flag_on_rise");
        check("irq_no_rise", {7'b0, irq_b}, 8'h00);
        gpio_b = 8'hA4;
        cycles(6);
        check("irq_fall2", {7'b0, irq_b}, 8'h01);
        bus_write(1'b0, A_MASK, 8'h00);
        check("irq_hold_mask_wr", {7'b0, irq_b}, 8'h01);
        cycles(1);
        check("irq_mask_off", {7'b0, irq_b}, 8'h00);
        bus_write(1'b0, A_EDGE, 8'hFF);

        // W1C colliding with a new rising event on bit1.
        bus_write(1'b0, A_MASK, 8'h02);
        gpio_b = 8'hA6;
        cycles(6);
        check("irq_bit1", {7'b0, irq_b}, 8'h01);
        check_reg(1'b0, A_EDGE, 8'h02, "edge_bit1");
        gpio_b = 8'hA4;
        cycles(6);
        check_reg(1'b0, A_EDGE, 8'h02, "edge_bit1_fall_ignored");
        gpio_b = 8'hA6;
        cycles(3);
        bus_write(1'b0, A_EDGE, 8'h02);
        check("collide_irq_0", {7'b0, irq_b}, 8'h01);
        cycles(1);
        check("collide_irq_1", {7'b0, irq_b}, 8'h01);
        check_reg(1'b0, A_EDGE, 8'h02, "collide_edge");

        // Reset in the middle of operation.
        bus_write(1'b0, A_POL, 8'h00);
        bus_write(1'b0, A_MASK, 8'hFF);
        gpio_b = 8'h00;
        cycles(6);
        gpio_b = 8'hFF;
        cycles(6);
        bus_write(1'b0, A_POL, 8'h5A);
        check_reg(1'b0, A_EDGE, 8'hFF, "pre_reset_edge");
        check("pre_reset_irq", {7'b0, irq_b}, 8'h01);
        reset = 1'b1; gpio_b = 8'h00;
        cycles(1);
        reset = 1'b0;
        check("irq_after_reset", {7'b0, irq_b}, 8'h00);
        check_reg(1'b0, A_EDGE, 8'h00, "edge_after_reset");
        check_reg(1'b0, A_MASK, 8'h00, "mask_after_reset");
        check_reg(1'b0, A_POL, 8'h00, "pol_after_reset");
        check_reg(1'b0, A_PIN, 8'h00, "pin_after_reset");

        // Randomized bus/pin activity against a transaction-level model.
        m_pin = '0; m_edge = '0; m_mask = '0; m_pol = '0;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            v  = 8'($urandom);
            case (op)
                0: begin
                    gpio_b = v;
                    rise   = ~m_pin & v;
                    fall   = m_pin & ~v;
                    m_edge = m_edge | (m_pol & fall) | (~m_pol & rise);
                    m_pin  = v;
                    cycles(5);
                end
                1: begin bus_write(1'b0, A_MASK, v); m_mask = v; end
                2: begin bus_write(1'b0, A_POL, v);  m_pol  = v; end
                default: begin bus_write(1'b0, A_EDGE, v); m_edge = m_edge & ~v; end
            endcase
            check_reg(1'b0, A_PIN,  m_pin,  "rnd_pin");
            check_reg(1'b0, A_EDGE, m_edge, "rnd_edge");
            check_reg(1'b0, A_MASK, m_mask, "rnd_mask");
            check_reg(1'b0, A_POL,  m_pol,  "rnd_pol");
            check("rnd_irq", {7'b0, irq_b}, {7'b0, |(m_edge & m_mask)});
        end

        // Glitch filter: 4-clk ticks, 3 ticks needed.
        gpio_f = 8'h08;
        cycles(8);
        gpio_f = 8'h00;
        cycles(30);
        check_reg(1'b1, A_PIN,  8'h00, "glitch_pin");
        check_reg(1'b1, A_EDGE, 8'h00, "glitch_edge");
        gpio_f = 8'h08;
        cycles(20);
        check_reg(1'b1, A_PIN,  8'h08, "hold_pin");
        check_reg(1'b1, A_EDGE, 8'h08, "hold_edge");
        check("flt_irq_masked", {7'b0, irq_f}, 8'h00);
        gpio_f = 8'h00;
        cycles(30);
        check_reg(1'b1, A_PIN, 8'h00, "hold_release_pin");
        bus_write(1'b1, A_EDGE, 8'hFF);
        check_reg(1'b1, A_EDGE, 8'h00, "flt_w1c");

        // Random pulses: <=8 clk always spans <3 ticks, >=12 clk always >=3.
        for (int it = 0; it < 12; it++) begin
            b           = $urandom_range(0, 7);
            short_pulse = 1'($urandom_range(0, 1));
            len         = short_pulse ? $urandom_range(1, 8) : $urandom_range(12, 24);
            one_hot     = 8'h01 << b;
            gpio_f = one_hot;
            cycles(len);
            gpio_f = 8'h00;
            cycles(30);
            check_reg(1'b1, A_EDGE, short_pulse ? 8'h00 : one_hot, "rnd_pulse_edge");
            check_reg(1'b1, A_PIN, 8'h00, "rnd_pulse_pin");
            bus_write(1'b1, A_EDGE, 8'hFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
